// File: rtl/run_length_detector.sv
// -----------------------------------------------------------------------------
// run_length_detector
//   Parametrised Moore run detector for serial bit streams. Counts consecutive
//   accepted bits equal to MATCH_VAL and raises `out` while the run count has
//   reached RUN_LEN. The overlap input selects whether a detection restarts
//   the count (0) or is sustained by further matching bits (1).
//
//   Optional feature macro: RUN_DET_COUNT_EN
//     defined   -> det_cnt counts detection events, saturating, det_clr clears
//     undefined -> det_cnt tied to 0, det_clr ignored, no counter flops
//
// Parameters
//   RUN_LEN    run length to detect (2..255)
//   MATCH_VAL  bit value that extends a run
//   CNT_W      width of det_cnt (1..32)
//   STATE_W    derived width of the run counter; do not override
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous, active-high reset
//   in_valid  qualifies `in`; state holds when low
//   in        serial data bit
//   overlap   0: restart after detect, 1: sustain on continued run
//   det_clr   synchronous clear of det_cnt
//   state     registered run count 0..RUN_LEN
//   out       Moore output, high while state == RUN_LEN
//   det_cnt   saturating number of detection events
// -----------------------------------------------------------------------------
module run_length_detector #(
  parameter int   RUN_LEN   = 3,
  parameter logic MATCH_VAL = 1'b1,
  parameter int   CNT_W     = 8,
  parameter int   STATE_W   = $clog2(RUN_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in,
  input  logic               overlap,
  input  logic               det_clr,
  output logic [STATE_W-1:0] state,
  output logic               out,
  output logic [CNT_W-1:0]   det_cnt
);

  localparam logic [STATE_W-1:0] ST_IDLE = '0;
  localparam logic [STATE_W-1:0] ST_DET  = STATE_W'(RUN_LEN);

  logic [STATE_W-1:0] state_nxt;
  logic               match;
  logic               det_evt;

  assign match = (in == MATCH_VAL);

  always_comb begin
    state_nxt = state;
    if (state > ST_DET) begin
      // Encodings above RUN_LEN are unreachable; recover regardless of valid.
      state_nxt = ST_IDLE;
    end else if (in_valid) begin
      if (state == ST_DET) begin
        state_nxt = (overlap && match) ? ST_DET : ST_IDLE;
      end else begin
        state_nxt = match ? (state + 1'b1) : ST_IDLE;
      end
    end
  end

  // One event per accepted bit landing in the detect state; a held detect
  // state (in_valid low) is not a new event.
  assign det_evt = in_valid && (state <= ST_DET) && (state_nxt == ST_DET);

  // Run-count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Output decoded from registered state only
  assign out = (state == ST_DET);

`ifdef RUN_DET_COUNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Detection counter; clear wins over a same-cycle event
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      det_cnt <= '0;
    end else if (det_clr) begin
      det_cnt <= '0;
    end else if (det_evt) begin
      det_cnt <= sat_inc(det_cnt);
    end
  end
`else
  logic unused_cnt_inputs;
  assign unused_cnt_inputs = det_clr ^ det_evt;
  assign det_cnt = '0;
`endif

endmodule
